// File: rtl/dvi_raster_timing.sv
// Raster timing generator feeding the VGA display driver: pixel coordinates,
// active-video qualifier and sync/blank delayed to match the driver's latency.
`ifndef log2NUM_COLS
`define log2NUM_COLS 10
`endif
`ifndef log2NUM_ROWS
`define log2NUM_ROWS 10
`endif

module dvi_raster_timing #(
   parameter int H_ACTIVE   = 1024,
   parameter int H_FP       = 24,
   parameter int H_SYNC     = 136,
   parameter int H_BP       = 160,
   parameter int V_ACTIVE   = 768,
   parameter int V_FP       = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 29,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int PIPE_DELAY = 2,
   parameter int CNT_X_W    = 11,
   parameter int CNT_Y_W    = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pix_en,
   output logic [`log2NUM_COLS-1:0]   XPos,
   output logic [`log2NUM_ROWS-1:0]   YPos,
   output logic                       Valid,
   output logic                       line_start,
   output logic                       frame_start,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       blank
);

   localparam int XW      = `log2NUM_COLS;
   localparam int YW      = `log2NUM_ROWS;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_X_W-1:0] H_LAST = CNT_X_W'(H_TOTAL - 1);
   localparam logic [CNT_Y_W-1:0] V_LAST = CNT_Y_W'(V_TOTAL - 1);

   localparam logic [31:0] H_ACT_E = 32'(H_ACTIVE);
   localparam logic [31:0] HS_BEG  = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_END  = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] V_ACT_E = 32'(V_ACTIVE);
   localparam logic [31:0] VS_BEG  = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_END  = 32'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > (2 ** CNT_X_W)) begin : g_err_cnt_x
      $error("CNT_X_W too narrow for H_TOTAL-1");
   end
   if (V_TOTAL > (2 ** CNT_Y_W)) begin : g_err_cnt_y
      $error("CNT_Y_W too narrow for V_TOTAL-1");
   end
   if (H_ACTIVE > (2 ** XW)) begin : g_err_xpos
      $error("XPos width too narrow for H_ACTIVE-1");
   end
   if (V_ACTIVE > (2 ** YW)) begin : g_err_ypos
      $error("YPos width too narrow for V_ACTIVE-1");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_err_pipe
      $error("PIPE_DELAY must be within 0..4");
   end

   logic [CNT_X_W-1:0] r_h_cnt;
   logic [CNT_Y_W-1:0] r_v_cnt;
   logic               r_running;

   logic [31:0] w_h32;
   logic [31:0] w_v32;
   logic        w_valid;
   logic        w_hs_raw;
   logic        w_vs_raw;
   logic        w_hs_lvl;
   logic        w_vs_lvl;
   logic        w_blank;

   // Counters hold on the first edge after reset so (0,0) is shown for a
   // full pixel before advancing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt   <= '0;
         r_v_cnt   <= '0;
         r_running <= 1'b0;
      end else if (!r_running) begin
         r_running <= 1'b1;
      end else if (pix_en) begin
         if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == V_LAST) begin
               r_v_cnt <= '0;
            end else begin
               r_v_cnt <= r_v_cnt + 1'b1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
      end
   end

   assign w_h32 = 32'(r_h_cnt);
   assign w_v32 = 32'(r_v_cnt);

   assign w_valid  = r_running && (w_h32 < H_ACT_E) && (w_v32 < V_ACT_E);
   assign w_hs_raw = r_running && (w_h32 >= HS_BEG) && (w_h32 < HS_END);
   assign w_vs_raw = r_running && (w_v32 >= VS_BEG) && (w_v32 < VS_END);

   assign w_hs_lvl = w_hs_raw ? HS_POL : !HS_POL;
   assign w_vs_lvl = w_vs_raw ? VS_POL : !VS_POL;
   assign w_blank  = !w_valid;

   assign XPos        = XW'(r_h_cnt);
   assign YPos        = YW'(r_v_cnt);
   assign Valid       = w_valid;
   assign line_start  = r_running && pix_en && (r_h_cnt == '0);
   assign frame_start = line_start && (r_v_cnt == '0);

   if (PIPE_DELAY == 0) begin : g_nopipe
      assign hsync = w_hs_lvl;
      assign vsync = w_vs_lvl;
      assign blank = w_blank;
   end else begin : g_pipe
      logic [PIPE_DELAY-1:0] r_hs_d;
      logic [PIPE_DELAY-1:0] r_vs_d;
      logic [PIPE_DELAY-1:0] r_bl_d;

      // Free-running shift: the driver's RGB register is not gated by pix_en.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_hs_d <= {PIPE_DELAY{!HS_POL}};
            r_vs_d <= {PIPE_DELAY{!VS_POL}};
            r_bl_d <= '1;
         end else begin
            r_hs_d[0] <= w_hs_lvl;
            r_vs_d[0] <= w_vs_lvl;
            r_bl_d[0] <= w_blank;
            for (int i = 1; i < PIPE_DELAY; i++) begin
               r_hs_d[i] <= r_hs_d[i-1];
               r_vs_d[i] <= r_vs_d[i-1];
               r_bl_d[i] <= r_bl_d[i-1];
            end
         end
      end

      assign hsync = r_hs_d[PIPE_DELAY-1];
      assign vsync = r_vs_d[PIPE_DELAY-1];
      assign blank = r_bl_d[PIPE_DELAY-1];
   end

endmodule

// File: doc/dvi_raster_timing.md
Name: dvi_raster_timing

Overview:
- Raster timing generator that sits directly upstream of the FPA VGA display driver.
- Produces the pixel coordinates (XPos, YPos) and the active-video qualifier (Valid) that the driver decodes into characters.
- Also produces hsync, vsync and blank, delayed through a configurable pipeline so they line up with the driver's registered RGB output at the DVI encoder.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIPE_DELAY, 2, clk stages applied to hsync/vsync/blank; matches display-driver latency; legal range 0..4
- CNT_X_W, 11, horizontal counter width; must hold H_TOTAL-1
- CNT_Y_W, 10, vertical counter width; must hold V_TOTAL-1

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel advance enable; tie high for one pixel per clk
- XPos  out  `log2NUM_COLS  current column; low bits of h counter
- YPos  out  `log2NUM_ROWS  current row; low bits of v counter
- Valid  out  1  current pixel is in the active region; undelayed, aligned with XPos/YPos
- line_start  out  1  single pixel-enable pulse at h==0
- frame_start  out  1  single pixel-enable pulse at h==0, v==0
- hsync  out  1  delayed PIPE_DELAY clks, polarity HS_POL
- vsync  out  1  delayed PIPE_DELAY clks, polarity VS_POL
- blank  out  1  delayed PIPE_DELAY clks; equals ~Valid

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- State: registers h_cnt, v_cnt and running.
  - reset=1 on a clk edge: h_cnt=0, v_cnt=0, running=0, every sync shift stage loaded with its deasserted level, blank stages loaded with 1.
  - First edge with reset=0: running<=1; counters are held.
- Advance: on an edge where running & pix_en:
  - h_cnt<=h_cnt+1.
  - At h_cnt==H_TOTAL-1: h_cnt<=0 and v_cnt<=v_cnt+1.
  - At v_cnt==V_TOTAL-1 on the same edge: v_cnt<=0.
  - pix_en=0 freezes both counters.
- Combinational decode from registers:
  - Valid = running & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - line_start = running & pix_en & h_cnt==0.
  - frame_start = line_start & v_cnt==0.
- Sync decode:
  - hs_raw is active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
  - vs_raw is active while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 771..776). It changes only at the h wrap.
  - Both are forced inactive when running=0.
- Delay line:
  - hs_raw, vs_raw and ~Valid pass through PIPE_DELAY registers. The delay line shifts on every clk, not gated by pix_en.
  - PIPE_DELAY=0 means a combinational pass-through.
  - Active level is applied before the delay line: hsync = delayed(hs_raw ? HS_POL : ~HS_POL); vsync likewise with VS_POL.
- Reset outputs (during reset and the first clk after release): XPos=0, YPos=0, Valid=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL, blank=1.
- XPos/YPos are valid only when Valid=1; truncation of counters above the port widths during blanking is permitted.
- Reset mid-frame: takes effect at the next edge, with no completion of the line or frame. The delay line flushes to deasserted values in the same edge.
- Reset asserted together with pix_en: reset wins.
- Elaboration error if CNT_X_W/CNT_Y_W cannot hold the totals, or if `log2NUM_COLS/`log2NUM_ROWS cannot hold H_ACTIVE-1/V_ACTIVE-1.

Test Plan:
- Reset values: reset high 5 clks, pix_en=1 -> XPos=0, YPos=0, Valid=0, hsync=1, vsync=1, blank=1 throughout and for 1 clk after release. Next clk -> Valid=1, frame_start=1, line_start=1 at (0,0).
- Horizontal timing, defaults, pix_en=1 -> Valid high for h 0..1023. Raw hsync low for h 1048..1183; the hsync port shows it 2 clks later. Line period is exactly 1344 clks between line_start pulses.
- Frame wrap -> (1343,805) is followed by (0,0) with frame_start=1. vsync is low for exactly 6 lines (v 771..776). Frame period is 1344*806 = 1083264 clks.
- pix_en=1 every other clk -> counters advance every 2 clks. frame_start/line_start are asserted only on enable cycles. blank still tracks ~Valid delayed by 2 clks.
- Reset at (500,300) -> next edge gives (0,0), Valid=0, hsync/vsync deasserted immediately. Restart matches the first scenario.
- PIPE_DELAY=0 build -> blank == ~Valid combinationally. With small params (H 8/1/2/1, V 4/1/1/1) -> hsync/vsync windows at h 9..10 and v 5.
